// File: rtl/mips_regfile_write_arbiter_if.sv
// Writeback bundle between the two result sources and the shared register-file write port.
interface mips_regfile_write_arbiter_if #(parameter int DATA_W = 32);
   logic              alu_valid;
   logic              alu_ready;
   logic [4:0]        alu_dst;
   logic [DATA_W-1:0] alu_data;
   logic              mem_valid;
   logic              mem_ready;
   logic [4:0]        mem_dst;
   logic [DATA_W-1:0] mem_data;
   logic              rf_write_enable;
   logic [4:0]        rf_dst_addr;
   logic [DATA_W-1:0] rf_write_data;
   logic [31:0]       pending_mask;
   logic              busy;

   modport master (
      output alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
      input  alu_ready, mem_ready, rf_write_enable, rf_dst_addr, rf_write_data,
             pending_mask, busy
   );

   modport slave (
      input  alu_valid, alu_dst, alu_data, mem_valid, mem_dst, mem_data,
      output alu_ready, mem_ready, rf_write_enable, rf_dst_addr, rf_write_data,
             pending_mask, busy
   );
endinterface

// File: rtl/mips_regfile_write_arbiter.sv
// Two per-source writeback FIFOs drained round-robin into one registered register-file write port,
// plus a pending-write mask for decode-stage RAW stall detection.
module mips_regfile_write_arbiter #(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 32
) (
   input logic                          clk,
   input logic                          reset,
   mips_regfile_write_arbiter_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   typedef logic [AW:0] ptr_t;

   // source index 0 = ALU, 1 = load
   logic [4:0]        dst_q [2][DEPTH];
   logic [4:0]        dst_d [2][DEPTH];
   logic [DATA_W-1:0] dat_q [2][DEPTH];
   logic [DATA_W-1:0] dat_d [2][DEPTH];
   ptr_t              wptr_q [2];
   ptr_t              wptr_d [2];
   ptr_t              rptr_q [2];
   ptr_t              rptr_d [2];
   logic              rr_q, rr_d;
   logic              we_q, we_d;
   logic [4:0]        addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;

   logic [1:0]        in_valid, full, nonempty, push, pop;
   logic [4:0]        in_dst [2];
   logic [DATA_W-1:0] in_data [2];
   logic [AW-1:0]     off;
   ptr_t              cnt;
   logic [31:0]       mask;

   always_comb begin
      in_valid   = {bus.mem_valid, bus.alu_valid};
      in_dst[0]  = bus.alu_dst;
      in_dst[1]  = bus.mem_dst;
      in_data[0] = bus.alu_data;
      in_data[1] = bus.mem_data;
      for (int s = 0; s < 2; s++) begin
         nonempty[s] = (wptr_q[s] != rptr_q[s]);
         full[s]     = (wptr_q[s][AW] != rptr_q[s][AW]) &&
                       (wptr_q[s][AW-1:0] == rptr_q[s][AW-1:0]);
         // dst 0 completes the handshake but is dropped here
         push[s]     = in_valid[s] && !full[s] && (in_dst[s] != 5'd0);
      end
      pop[0] = nonempty[0] && (!nonempty[1] || !rr_q);
      pop[1] = nonempty[1] && !pop[0];
   end

   always_comb begin
      dst_d   = dst_q;
      dat_d   = dat_q;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      rr_d    = rr_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      for (int s = 0; s < 2; s++) begin
         if (push[s]) begin
            dst_d[s][wptr_q[s][AW-1:0]] = in_dst[s];
            dat_d[s][wptr_q[s][AW-1:0]] = in_data[s];
            wptr_d[s] = wptr_q[s] + ptr_t'(1);
         end
         if (pop[s]) begin
            rptr_d[s] = rptr_q[s] + ptr_t'(1);
            we_d      = 1'b1;
            addr_d    = dst_q[s][rptr_q[s][AW-1:0]];
            wdata_d   = dat_q[s][rptr_q[s][AW-1:0]];
            rr_d      = (s == 0);
         end
      end
   end

   always_comb begin
      mask = 32'd0;
      off  = '0;
      cnt  = '0;
      for (int s = 0; s < 2; s++) begin
         cnt = wptr_q[s] - rptr_q[s];
         for (int j = 0; j < DEPTH; j++) begin
            off = j[AW-1:0] - rptr_q[s][AW-1:0];
            if ({1'b0, off} < cnt) mask[dst_q[s][j]] = 1'b1;
         end
      end
      if (we_q) mask[addr_q] = 1'b1;
      mask[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < 2; s++) begin
            for (int j = 0; j < DEPTH; j++) begin
               dst_q[s][j] <= '0;
               dat_q[s][j] <= '0;
            end
            wptr_q[s] <= '0;
            rptr_q[s] <= '0;
         end
         rr_q    <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         dst_q   <= dst_d;
         dat_q   <= dat_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   assign bus.alu_ready       = !full[0];
   assign bus.mem_ready       = !full[1];
   assign bus.rf_write_enable = we_q;
   assign bus.rf_dst_addr     = addr_q;
   assign bus.rf_write_data   = wdata_q;
   assign bus.pending_mask    = mask;
   assign bus.busy            = nonempty[0] || nonempty[1] || we_q;
endmodule

// File: tb/tb_mips_regfile_write_arbiter.sv
// Scoreboard bench for the writeback arbiter: accepted requests are queued per source and
// retired against register-file writes; per-scenario tasks add ordering/timing checks.
module tb_mips_regfile_write_arbiter;
   typedef struct packed {
      logic [4:0]  dst;
      logic [31:0] data;
   } wr_t;

   logic clk;
   logic reset;
   int   compared;
   int   mismatched;
   int   cyc;

   wr_t         exp_alu[$];
   wr_t         exp_mem[$];
   logic [4:0]  log_dst[$];
   int          log_cyc[$];

   mips_regfile_write_arbiter_if #(.DATA_W(32)) bus ();

   mips_regfile_write_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      wr_t got;
      if (reset && bus.rf_write_enable === 1'b1) begin
         got.dst  = bus.rf_dst_addr;
         got.data = bus.rf_write_data;
         log_dst.push_back(got.dst);
         log_cyc.push_back(cyc);
         compared++;
         if (exp_alu.size() > 0 && exp_alu[0] == got) void'(exp_alu.pop_front());
         else if (exp_mem.size() > 0 && exp_mem[0] == got) void'(exp_mem.pop_front());
         else begin
            mismatched++;
            $display("FAIL scoreboard: write dst=%0d data=%h is not at the head of any expected queue",
                     got.dst, got.data);
         end
      end
   end

   task automatic drive(input logic av, input logic [4:0] ad, input logic [31:0] adat,
                        input logic mv, input logic [4:0] md, input logic [31:0] mdat,
                        output logic acc_a, output logic acc_m);
      @(negedge clk);
      bus.alu_valid = av;
      bus.alu_dst   = ad;
      bus.alu_data  = adat;
      bus.mem_valid = mv;
      bus.mem_dst   = md;
      bus.mem_data  = mdat;
      #1;
      acc_a = av && bus.alu_ready;
      acc_m = mv && bus.mem_ready;
      if (acc_a && ad != 5'd0) exp_alu.push_back({ad, adat});
      if (acc_m && md != 5'd0) exp_mem.push_back({md, mdat});
   endtask

   task automatic idle_inputs();
      bus.alu_valid = 1'b0;
      bus.mem_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      bit done;
      done = 0;
      @(negedge clk);
      idle_inputs();
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         #1;
         if (bus.busy === 1'b0) done = 1;
      end
      compared++;
      if (!done) begin
         mismatched++;
         $display("FAIL %s_drain: busy still %b after 60 cycles, required 0", name, bus.busy);
      end
      compared++;
      if (exp_alu.size() != 0 || exp_mem.size() != 0) begin
         mismatched++;
         $display("FAIL %s_lost: %0d alu / %0d mem writes never appeared, required 0 / 0",
                  name, exp_alu.size(), exp_mem.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      bus.alu_dst = '0; bus.alu_data = '0; bus.mem_dst = '0; bus.mem_data = '0;
      repeat (3) @(negedge clk);
      #1;
      compared++;
      if ({bus.rf_write_enable, bus.rf_dst_addr, bus.rf_write_data} !== 38'd0) begin
         mismatched++;
         $display("FAIL reset_out: we=%b addr=%0d data=%h, required 0/0/0",
                  bus.rf_write_enable, bus.rf_dst_addr, bus.rf_write_data);
      end
      compared++;
      if (bus.pending_mask !== 32'd0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_mask: mask=%h busy=%b, required 0/0", bus.pending_mask, bus.busy);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      compared++;
      if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
         mismatched++;
         $display("FAIL reset_ready: alu_ready=%b mem_ready=%b, required 1/1", bus.alu_ready, bus.mem_ready);
      end
   endtask

   task automatic test_contention();
      logic a, m;
      log_dst.delete(); log_cyc.delete();
      drive(1, 5'd3, 32'h11, 1, 5'd4, 32'h22, a, m);
      drive(1, 5'd6, 32'h33, 1, 5'd7, 32'h44, a, m);
      wait_idle("contention");
      compared++;
      if (log_dst.size() != 4 || log_dst[0] !== 5'd3 || log_dst[1] !== 5'd4 ||
          log_dst[2] !== 5'd6 || log_dst[3] !== 5'd7) begin
         mismatched++;
         $display("FAIL contention_order: %0d writes, first dst=%0d, required 4 writes ordered 3,4,6,7",
                  log_dst.size(), (log_dst.size() > 0) ? log_dst[0] : 5'd0);
      end else begin
         compared++;
         if (log_cyc[3] - log_cyc[0] != 3) begin
            mismatched++;
            $display("FAIL contention_gap: writes spread over %0d cycles, required 3", log_cyc[3] - log_cyc[0]);
         end
      end
   endtask

   task automatic test_backpressure();
      logic a, m;
      int ai, mi;
      bit saw_low;
      logic [4:0] mem_seen[$];
      ai = 0; mi = 0; saw_low = 0;
      log_dst.delete(); log_cyc.delete();
      for (int c = 0; c < 40 && (ai < 4 || mi < 4); c++) begin
         drive(ai < 4, 5'(8 + ai), 32'hA0 + ai, mi < 4, 5'(12 + mi), 32'hB0 + mi, a, m);
         if (mi < 4 && !m) saw_low = 1;
         if (a) ai++;
         if (m) mi++;
      end
      wait_idle("backpressure");
      compared++;
      if (!saw_low) begin
         mismatched++;
         $display("FAIL bp_ready: mem_ready never dropped, required a low cycle with 2 queued loads");
      end
      foreach (log_dst[i]) if (log_dst[i] >= 5'd12) mem_seen.push_back(log_dst[i]);
      compared++;
      if (log_dst.size() != 8 || mem_seen.size() != 4 || mem_seen[0] !== 5'd12 ||
          mem_seen[1] !== 5'd13 || mem_seen[2] !== 5'd14 || mem_seen[3] !== 5'd15) begin
         mismatched++;
         $display("FAIL bp_order: %0d writes with %0d loads, required 8 writes with loads 12,13,14,15 in order",
                  log_dst.size(), mem_seen.size());
      end
   endtask

   task automatic test_single();
      logic a, m;
      drive(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, a, m);
      @(negedge clk);
      idle_inputs();
      #1;
      compared++;
      if (bus.pending_mask !== 32'h0000_0020 || bus.rf_write_enable !== 1'b0) begin
         mismatched++;
         $display("FAIL single_queued: mask=%h we=%b, required 00000020/0", bus.pending_mask, bus.rf_write_enable);
      end
      @(negedge clk);
      #1;
      compared++;
      if (bus.rf_write_enable !== 1'b1 || bus.rf_dst_addr !== 5'd5 ||
          bus.rf_write_data !== 32'hDEADBEEF || bus.pending_mask !== 32'h0000_0020) begin
         mismatched++;
         $display("FAIL single_write: we=%b addr=%0d data=%h mask=%h, required 1/5/deadbeef/00000020",
                  bus.rf_write_enable, bus.rf_dst_addr, bus.rf_write_data, bus.pending_mask);
      end
      @(negedge clk);
      #1;
      compared++;
      if (bus.rf_write_enable !== 1'b0 || bus.pending_mask !== 32'd0 || bus.busy !== 1'b0 ||
          bus.rf_dst_addr !== 5'd5 || bus.rf_write_data !== 32'hDEADBEEF) begin
         mismatched++;
         $display("FAIL single_done: we=%b mask=%h busy=%b addr=%0d data=%h, required 0/0/0/5/deadbeef",
                  bus.rf_write_enable, bus.pending_mask, bus.busy, bus.rf_dst_addr, bus.rf_write_data);
      end
   endtask

   task automatic test_dst0();
      logic a, m;
      drive(1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'd0, a, m);
      compared++;
      if (a !== 1'b1) begin
         mismatched++;
         $display("FAIL dst0_ready: alu_ready=%b, required 1", a);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         idle_inputs();
         #1;
         compared++;
         if (bus.rf_write_enable !== 1'b0 || bus.pending_mask !== 32'd0 || bus.busy !== 1'b0) begin
            mismatched++;
            $display("FAIL dst0_quiet: cycle %0d we=%b mask=%h busy=%b, required 0/0/0",
                     i, bus.rf_write_enable, bus.pending_mask, bus.busy);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic a, m;
      bit ok;
      log_dst.delete(); log_cyc.delete();
      for (int i = 1; i <= 10; i++) begin
         a = 0;
         for (int t = 0; t < 10 && !a; t++) drive(1, 5'(i), 32'(i), 0, 5'd0, 32'd0, a, m);
      end
      wait_idle("wrap");
      ok = (log_dst.size() == 10);
      if (ok) foreach (log_dst[i]) begin
         if (log_dst[i] !== 5'(i + 1)) ok = 0;
         if (i > 0 && log_cyc[i] - log_cyc[i-1] != 1) ok = 0;
      end
      compared++;
      if (!ok) begin
         mismatched++;
         $display("FAIL wrap_stream: %0d writes, required 10 consecutive writes to dst 1..10", log_dst.size());
      end
   endtask

   task automatic test_reset_mid();
      logic a, m;
      drive(1, 5'd20, 32'h200, 1, 5'd21, 32'h210, a, m);
      drive(1, 5'd22, 32'h220, 0, 5'd0, 32'd0, a, m);
      @(negedge clk);
      idle_inputs();
      #1;
      compared++;
      if (bus.busy !== 1'b1 || bus.pending_mask[22] !== 1'b1) begin
         mismatched++;
         $display("FAIL midreset_pre: busy=%b mask=%h, required busy 1 with bit 22 set", bus.busy, bus.pending_mask);
      end
      #1;
      reset = 1'b0;
      #1;
      compared++;
      if (bus.rf_write_enable !== 1'b0 || bus.pending_mask !== 32'd0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_clear: we=%b mask=%h busy=%b, required 0/0/0",
                  bus.rf_write_enable, bus.pending_mask, bus.busy);
      end
      exp_alu.delete(); exp_mem.delete();
      log_dst.delete(); log_cyc.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      compared++;
      if (log_dst.size() != 0 || bus.busy !== 1'b0) begin
         mismatched++;
         $display("FAIL midreset_stale: %0d writes after release, busy=%b, required 0/0", log_dst.size(), bus.busy);
      end
   endtask

   initial begin
      compared = 0;
      mismatched = 0;
      cyc = 0;
      test_reset();
      test_contention();
      test_backpressure();
      test_single();
      test_dst0();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/mips_regfile_write_arbiter.md
Name: mips_regfile_write_arbiter

Overview:
- Shares the single register-file write port between two writeback sources:
  - ALU/execute results.
  - Memory load results.
- Each source has a small FIFO with a valid/ready handshake.
- A round-robin arbiter drains the FIFOs into registered write-port outputs.
- Publishes a pending-write scoreboard mask, which the decode stage uses for RAW stall detection.

Parameters:
DEPTH, 2, entries per source FIFO (power of two, 2..8)
DATA_W, 32, write data width

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
alu_valid  input  1  ALU writeback request
alu_ready  output  1  ALU FIFO can accept
alu_dst  input  5  ALU destination register
alu_data  input  DATA_W  ALU result
mem_valid  input  1  load writeback request
mem_ready  output  1  load FIFO can accept
mem_dst  input  5  load destination register
mem_data  input  DATA_W  load data
rf_write_enable  output  1  register file write enable
rf_dst_addr  output  5  register file write address
rf_write_data  output  DATA_W  register file write data
pending_mask  output  32  bit i = write to register i queued or in output stage
busy  output  1  any FIFO non-empty or rf_write_enable high

Behaviour:
- Reset (reset = 0, asynchronous):
  - Both FIFOs empty.
  - rf_write_enable = 0, rf_dst_addr = 0, rf_write_data = 0.
  - pending_mask = 0, busy = 0.
  - Round-robin pointer = ALU-first.
  - alu_ready/mem_ready = 1 once reset = 1.
- Reset mid-operation discards all queued writes; none reach the write port.
- Handshake:
  - Transfer occurs at a rising edge where valid && ready.
  - ready = FIFO not full, combinational from FIFO state only, never from valid.
  - A FIFO that is full at an edge where it is popped does not accept that cycle; ready stays low that cycle.
- dst = 0: transfer is completed (ready honoured) but discarded; never enqueued, never written, never sets pending_mask.
- FIFO ordering: per-source order is preserved. Cross-source ordering to the same register is not guaranteed; the pipeline must not issue conflicting writes from both sources concurrently.
- Arbitration, evaluated each cycle on FIFO heads:
  - Neither FIFO non-empty: no pop.
  - One FIFO non-empty: pop it.
  - Both non-empty: pop the source indicated by the round-robin pointer; pointer then flips to the other source.
  - A pop with a single requester also sets the pointer to the other source.
- Output stage:
  - The popped entry is registered into rf_dst_addr/rf_write_data with rf_write_enable = 1 for exactly one cycle.
  - With no pop, rf_write_enable = 0 and addr/data hold their last values.
- Latency and throughput:
  - Request accepted at edge k into an empty FIFO with no contention → rf_write_enable high in the cycle after edge k+1; the register file captures at edge k+2.
  - Sustained throughput: one write per cycle total.
- pending_mask:
  - Bitwise OR over all valid FIFO entries and the output stage (when rf_write_enable = 1) of the one-hot of dst.
  - Combinational from registered state.
  - Bit 0 is always 0.
- Simultaneous push and pop on the same FIFO is allowed; occupancy is unchanged.
- FIFO pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

Test Plan:
- Single ALU write: alu_valid = 1, dst = 5, data = 0xDEADBEEF for one cycle → rf_write_enable = 1 with addr 5 and that data exactly two edges later; pending_mask bit 5 set from edge k+1 until the write completes.
- Contention: both valid in the same cycle (ALU dst 3 = 0x11, mem dst 4 = 0x22), then both again (dst 6 = 0x33, dst 7 = 0x44) → write order 3, 4, 6, 7 on consecutive cycles.
- Backpressure with DEPTH = 2:
  - Hold mem_valid = 1 for 4 cycles with both sources streaming, ALU given priority by the pointer.
  - mem_ready must drop when the mem FIFO holds 2 entries.
  - No accepted entry is lost or duplicated.
  - All 4 loads are eventually written, in order.
- dst 0 discard: alu_valid with dst = 0, data = 0xFFFFFFFF → alu_ready = 1, no rf_write_enable pulse, pending_mask stays 0, busy stays 0.
- Reset mid-operation: queue 3 writes, assert reset = 0 asynchronously between edges → rf_write_enable, pending_mask, busy go 0 immediately; after release, no stale writes appear.
- Wrap-around: stream 10 back-to-back ALU writes, dst 1..10 with data = dst → 10 consecutive writes with matching addr/data, no gaps after the first.
